// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (MEM stage, byte-addressed) and debug (word-aligned)
// share one synchronous single-port RAM. Define DMEM_ARB_RR_EN for round-robin contention.

package dmem_arb_pkg;
    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } port_req_t;

    typedef struct packed {
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;
endpackage

// Per-port command formatter; SHIFT_EN lanes move right-aligned stores into their byte lanes.
module dmem_arb_lane
    import dmem_arb_pkg::*;
#(
    parameter bit SHIFT_EN = 1'b0
) (
    input  port_req_t i_req,
    output mem_cmd_t  o_cmd
);
    logic [1:0] w_off;

    assign w_off = SHIFT_EN ? i_req.addr[1:0] : 2'b00;

    always_comb begin
        o_cmd.addr  = i_req.addr[31:2];
        o_cmd.we    = i_req.we << w_off;
        o_cmd.wdata = i_req.wdata << {w_off, 3'b000};
    end
endmodule

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_req,
    input  logic [3:0]  i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic        o_cpu_gnt,
    output logic        o_cpu_rvalid,
    output logic [31:0] o_cpu_rdata,
    output logic [1:0]  o_cpu_rsel,
    input  logic        i_dbg_req,
    input  logic [3:0]  i_dbg_we,
    input  logic [31:0] i_dbg_addr,
    input  logic [31:0] i_dbg_wdata,
    output logic        o_dbg_gnt,
    output logic        o_dbg_rvalid,
    output logic [31:0] o_dbg_rdata,
    output logic        o_mem_en,
    output logic [3:0]  o_mem_we,
    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    localparam int NUM_PORTS = 2;

    port_req_t w_req [NUM_PORTS];
    mem_cmd_t  w_cmd [NUM_PORTS];
    mem_cmd_t  w_sel;
    logic      w_dbg_pri;
    logic      w_cpu_gnt;
    logic      w_dbg_gnt;
    owner_e    r_owner;
    owner_e    w_owner_nxt;
    logic [1:0] r_cpu_rsel;

    assign w_req[0] = '{we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata};
    assign w_req[1] = '{we: i_dbg_we, addr: i_dbg_addr, wdata: i_dbg_wdata};

    // Port 0 is the CPU and needs byte-lane alignment; port 1 (debug) passes through.
    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
            dmem_arb_lane #(.SHIFT_EN(g == 0)) u_lane (
                .i_req (w_req[g]),
                .o_cmd (w_cmd[g])
            );
        end
    endgenerate

`ifdef DMEM_ARB_RR_EN
    logic r_last_dbg;

    assign w_dbg_pri = ~r_last_dbg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_dbg <= 1'b1;
        end else if (w_cpu_gnt) begin
            r_last_dbg <= 1'b0;
        end else if (w_dbg_gnt) begin
            r_last_dbg <= 1'b1;
        end
    end
`else
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_wait_cnt;

    assign w_dbg_pri = (r_wait_cnt == LIM);

    // Counts consecutive cycles debug has been left waiting; saturates at the escape point.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (i_dbg_req && !w_dbg_gnt) begin
            if (r_wait_cnt != LIM) r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`endif

    // Grants are gated by reset so nothing reaches the RAM while rst_n is low.
    assign w_cpu_gnt = i_rst_n & i_cpu_req & ~(i_dbg_req & w_dbg_pri);
    assign w_dbg_gnt = i_rst_n & i_dbg_req & ~(i_cpu_req & ~w_dbg_pri);

    assign o_cpu_gnt = w_cpu_gnt;
    assign o_dbg_gnt = w_dbg_gnt;

    always_comb begin
        w_sel       = w_dbg_gnt ? w_cmd[1] : w_cmd[0];
        o_mem_en    = w_cpu_gnt | w_dbg_gnt;
        o_mem_we    = 4'b0000;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (o_mem_en) begin
            o_mem_we    = w_sel.we;
            o_mem_addr  = w_sel.addr;
            o_mem_wdata = w_sel.wdata;
        end
    end

    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_cpu_gnt && i_cpu_we == 4'b0000) begin
            w_owner_nxt = OWN_CPU;
        end else if (w_dbg_gnt && i_dbg_we == 4'b0000) begin
            w_owner_nxt = OWN_DBG;
        end
    end

    // Async clear drops any response still in flight when reset hits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner    <= OWN_NONE;
            r_cpu_rsel <= 2'b00;
        end else begin
            r_owner <= w_owner_nxt;
            if (w_owner_nxt == OWN_CPU) r_cpu_rsel <= i_cpu_addr[1:0];
        end
    end

    assign o_cpu_rvalid = (r_owner == OWN_CPU);
    assign o_dbg_rvalid = (r_owner == OWN_DBG);
    assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : 32'h0;
    assign o_dbg_rdata  = o_dbg_rvalid ? i_mem_rdata : 32'h0;
    assign o_cpu_rsel   = r_cpu_rsel;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: max consecutive cycles a pending debug request may lose arbitration (fixed-priority mode).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  CPU memory access request (MEM stage).
REQ-005 cpu_we  input  4  CPU byte-write enables, unshifted (0000 = read).
REQ-006 cpu_addr  input  32  CPU byte address; [1:0] may be non-zero.
REQ-007 cpu_wdata  input  32  CPU store data, right-aligned.
REQ-008 cpu_gnt  output  1  CPU request accepted this cycle.
REQ-009 cpu_rvalid  output  1  CPU read data valid.
REQ-010 cpu_rdata  output  32  raw memory word for CPU read.
REQ-011 cpu_rsel  output  2  byte offset of the completed CPU read, for downstream load extension.
REQ-012 dbg_req / dbg_we[3:0] / dbg_addr[31:0] / dbg_wdata[31:0]  input  debug requester, word-aligned, enables apply unshifted.
REQ-013 dbg_gnt  output  1;  dbg_rvalid  output  1;  dbg_rdata  output  32  debug grant and read response.
REQ-014 mem_en  output  1;  mem_we  output  4;  mem_addr  output  30;  mem_wdata  output  32  shared synchronous single-port RAM command.
REQ-015 mem_rdata  input  32  RAM read data, valid one cycle after the command.

Function
REQ-016 Grant is combinational from requests and registered arbitration state; at most one of cpu_gnt/dbg_gnt high; a grant never asserts without its request.
REQ-017 Single requester: that requester is granted the same cycle.
REQ-018 Contention, fixed-priority mode: CPU granted unless wait_cnt == STARVE_LIMIT, in which case debug granted.
REQ-019 wait_cnt: increments when dbg_req && !dbg_gnt, saturates at STARVE_LIMIT, clears when dbg_gnt or !dbg_req.
REQ-020 mem_en = cpu_gnt | dbg_gnt; when neither granted, mem_we, mem_addr, mem_wdata drive 0.
REQ-021 CPU granted: mem_addr = cpu_addr[31:2]; mem_we = (cpu_we << cpu_addr[1:0]) truncated to 4 bits; mem_wdata = cpu_wdata << (8*cpu_addr[1:0]), truncated to 32 bits.
REQ-022 Debug granted: mem_addr = dbg_addr[31:2]; mem_we = dbg_we; mem_wdata = dbg_wdata.
REQ-023 Read (granted, we == 0000) registers owner and cpu_addr[1:0]; next cycle owner's rvalid = 1 for exactly one cycle, its rdata = mem_rdata.
REQ-024 Non-owner rdata = 0; rvalid never asserts for writes; cpu_rsel holds last registered offset.
REQ-025 Back-to-back reads by either port every cycle are supported: one response per cycle, in grant order.
REQ-026 Requester not granted holds request stable; arbiter keeps no request queue.

Reset
REQ-027 rst_n low: wait_cnt = 0, owner = none, cpu_rvalid = dbg_rvalid = 0, cpu_rsel = 00, last_gnt = DBG, immediately, without clock.
REQ-028 Grants and mem_* are forced 0 while rst_n low.
REQ-029 Reset asserted with a read in flight: that response is dropped and never delivered.
REQ-030 First rising edge after rst_n release performs normal arbitration.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN defined: contention grants the port not recorded in last_gnt; last_gnt updates on every grant; wait_cnt held 0.
REQ-032 DMEM_ARB_RR_EN undefined: fixed priority with starvation escape per REQ-018/019; last_gnt unused.

Verification
REQ-033 CPU only, cpu_we=0001, cpu_addr=0x102, cpu_wdata=0xAB -> mem_we=0100, mem_addr=0x40, mem_wdata=0x00AB0000, cpu_gnt=1.
REQ-034 CPU read addr=0x203, mem_rdata=0x11223344 next cycle -> cpu_rvalid=1 one cycle, cpu_rdata=0x11223344, cpu_rsel=11, dbg_rvalid=0.
REQ-035 Fixed mode, both requesting continuously, STARVE_LIMIT=8 -> CPU granted cycles 0-7, debug cycle 8, CPU cycles 9-16.
REQ-036 DMEM_ARB_RR_EN, both requesting continuously after reset -> grants CPU, DBG, CPU, DBG alternating.
REQ-037 Debug read granted, rst_n pulsed low before next edge -> dbg_rvalid stays 0; all outputs 0 during reset.
REQ-038 No requests -> mem_en=0, mem_we=0000, mem_addr=0, no rvalid.
